// File: rtl/adrv9009_rsp_capture.sv
// adrv9009_rsp_capture
//   Triggered snapshot buffer for the ADRV9009 receive-path output stream.
//   On arm it records a pre-trigger history into a circular RAM, fires on a
//   signed rising crossing of threshold, records the post-trigger samples and
//   then streams the whole window out oldest-first on request.
//
// Ports
//   clk        system clock, one sample per rising edge
//   reset      synchronous, active-high
//   in         signed sample from the receiver signal path
//   arm        single-cycle pulse, starts a capture (IDLE or DONE only)
//   threshold  signed trigger level, held stable while busy
//   rd_en      readout request, one sample per asserted cycle (DONE only)
//   busy       high in PRE_FILL, ARMED and POST
//   triggered  high from the trigger cycle until the capture ends
//   done       high while the window is ready for readout
//   rd_data    readout sample (holds between reads)
//   rd_valid   rd_data valid, one cycle after rd_en
//   rd_last    final sample of the window, coincident with rd_valid
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for arm
// PRE_FILL | collecting the pre-trigger history, crossings ignored
// ARMED    | circular overwrite, watching for a rising crossing
// POST     | collecting samples after the trigger
// DONE     | window frozen, readout via rd_en

module adrv9009_rsp_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int PRE    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     arm,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     rd_en,
    output logic                     busy,
    output logic                     triggered,
    output logic                     done,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rd_last
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE - 1);
    localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t                     state;
    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          rd_ptr;
    logic [ADDR_W-1:0]          rd_cnt;
    logic [CNT_W-1:0]           pre_cnt;
    logic [CNT_W-1:0]           post_cnt;
    logic signed [DATA_W-1:0]   prev_in;
    logic                       prev_valid;
    logic                       wr_en;
    logic                       trig_hit;
    logic                       start;

    assign wr_en    = (state == PRE_FILL) || (state == ARMED) || (state == POST);
    assign trig_hit = prev_valid && (prev_in < threshold) && (in >= threshold);
    assign start    = arm && ((state == IDLE) || (state == DONE));

    // RAM is deliberately not reset; the reset gate only stops a stray write
    // on the abort edge.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            prev_in    <= '0;
            prev_valid <= 1'b0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;

            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev_in    <= in;
                prev_valid <= 1'b1;
            end

            if (start) begin
                // A new arm in DONE throws the window away; a same-cycle
                // rd_en is dropped.
                state      <= (PRE == 0) ? ARMED : PRE_FILL;
                wr_ptr     <= '0;
                pre_cnt    <= '0;
                post_cnt   <= '0;
                rd_cnt     <= '0;
                prev_valid <= 1'b0;
                busy       <= 1'b1;
                triggered  <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    PRE_FILL: begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt == PRE_LAST) begin
                            state <= ARMED;
                        end
                    end

                    ARMED: begin
                        if (trig_hit) begin
                            post_cnt <= CNT_W'(1);
                            if (DEPTH - PRE == 1) begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                rd_ptr    <= wr_ptr + 1'b1;
                                rd_cnt    <= '0;
                            end else begin
                                state     <= POST;
                                triggered <= 1'b1;
                            end
                        end
                    end

                    POST: begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == POST_LAST) begin
                            // Oldest sample sits where the next write would go.
                            state     <= DONE;
                            busy      <= 1'b0;
                            triggered <= 1'b0;
                            done      <= 1'b1;
                            rd_ptr    <= wr_ptr + 1'b1;
                            rd_cnt    <= '0;
                        end
                    end

                    DONE: begin
                        if (rd_en) begin
                            rd_data  <= mem[rd_ptr];
                            rd_valid <= 1'b1;
                            rd_ptr   <= rd_ptr + 1'b1;
                            rd_cnt   <= rd_cnt + 1'b1;
                            if (rd_cnt == RD_LAST) begin
                                rd_last <= 1'b1;
                                done    <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adrv9009_rsp_capture.sv
// Testbench for adrv9009_rsp_capture: table of capture scenarios plus
// hand-written reset / no-edge / rearm / abort sequences. Readout data is
// checked through a scoreboard queue filled as rd_en is driven.

module tb_adrv9009_rsp_capture;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int PRE    = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] in_s;
    logic                     arm;
    logic signed [DATA_W-1:0] threshold;
    logic                     rd_en;
    logic                     busy;
    logic                     triggered;
    logic                     done;
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_last;

    always #5 clk = ~clk;

    adrv9009_rsp_capture #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .PRE   (PRE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .arm      (arm),
        .threshold(threshold),
        .rd_en    (rd_en),
        .busy     (busy),
        .triggered(triggered),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int data;
        int last;
    } sb_t;
    sb_t sb[$];
    int  hold_data;

    typedef struct {
        int pat;
        int thr;
        int trig;
        int gaps;
    } vec_t;
    vec_t tbl[7];

    // pattern 0: ramp k, 1: square -50x4/+50x4, 2: ramp k-100, 3: constant 500
    function automatic int pat_val(input int pat, input int k);
        case (pat)
            0:       return k;
            1:       return (((k / 4) % 2) == 0) ? -50 : 50;
            2:       return k - 100;
            default: return 500;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int status();
        return int'({busy, triggered, done});
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_status"}, status(), 0);
        chk({name, "_rd_valid"}, int'(rd_valid), 0);
        chk({name, "_rd_last"}, int'(rd_last), 0);
        chk({name, "_rd_data"}, int'(rd_data), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        arm   = 1'b0;
        rd_en = 1'b0;
        step();
        chk_all_zero("reset");
        reset     = 1'b0;
        hold_data = 0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_status", status(), 4);
    endtask

    // Drives samples k = 0..n-1; expected {busy,triggered,done} follows from
    // the trigger index the caller expects (-1 = never triggers).
    task automatic fill(input int pat, input int thr, input int trig, input int n);
        int done_k;
        int e;
        done_k    = trig + DEPTH - PRE - 1;
        threshold = DATA_W'(thr);
        for (int k = 0; k < n; k++) begin
            in_s = DATA_W'(pat_val(pat, k));
            step();
            if (trig < 0 || k < trig) e = 4;
            else if (k < done_k)      e = 6;
            else                      e = 1;
            chk($sformatf("status_k%0d", k), status(), e);
            chk("fill_rd_valid", int'(rd_valid), 0);
            if (trig >= 0 && k == done_k) break;
        end
    endtask

    task automatic check_rd(input int en);
        sb_t e;
        chk("rd_valid", int'(rd_valid), en);
        if (rd_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: got rd_valid with data %0d, expected no output", int'(rd_data));
            end else begin
                e = sb.pop_front();
                chk("rd_data", int'(rd_data), e.data);
                chk("rd_last", int'(rd_last), e.last);
                if (e.last != 0) chk("done_at_last", int'(done), 0);
                hold_data = int'(rd_data);
            end
        end else begin
            chk("rd_last_idle", int'(rd_last), 0);
            chk("rd_data_hold", int'(rd_data), hold_data);
        end
    endtask

    task automatic readout(input int pat, input int trig, input int gaps, input int n);
        int  issued;
        int  en;
        sb_t e;
        issued = 0;
        for (int c = 0; c < 4 * DEPTH && issued < n; c++) begin
            en    = (gaps != 0 && (c % 3) == 2) ? 0 : 1;
            rd_en = en[0];
            if (en != 0) begin
                e.data = pat_val(pat, trig - PRE + issued);
                e.last = (issued == DEPTH - 1) ? 1 : 0;
                sb.push_back(e);
                issued++;
            end
            step();
            check_rd(en);
        end
        rd_en = 1'b0;
        if (n == DEPTH) begin
            step();
            check_rd(0);
            chk("end_status", status(), 0);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        tbl[0] = '{0,  20,  20, 0};
        tbl[1] = '{1,   0,  20, 1};
        tbl[2] = '{0,  30,  30, 0};
        tbl[3] = '{2, -60,  40, 1};
        tbl[4] = '{0,  16,  16, 0};
        tbl[5] = '{0,  15,  -1, 0};
        tbl[6] = '{0,   3,  -1, 0};

        reset     = 1'b1;
        arm       = 1'b1;
        rd_en     = 1'b1;
        in_s      = '0;
        threshold = '0;
        hold_data = 0;
        repeat (2) begin
            step();
            chk_all_zero("init_reset");
        end
        reset = 1'b0;
        arm   = 1'b0;
        rd_en = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            do_arm();
            if (tbl[v].trig >= 0) begin
                fill(tbl[v].pat, tbl[v].thr, tbl[v].trig, 200);
                readout(tbl[v].pat, tbl[v].trig, tbl[v].gaps, DEPTH);
            end else begin
                fill(tbl[v].pat, tbl[v].thr, -1, 150);
                apply_reset();
            end
        end

        // Constant input above threshold never triggers; rd_en is ignored.
        do_arm();
        rd_en = 1'b1;
        fill(3, 100, -1, 1000);
        rd_en = 1'b0;
        apply_reset();

        // Rearm from DONE part-way through readout.
        do_arm();
        fill(0, 20, 20, 200);
        readout(0, 20, 0, 10);
        arm   = 1'b1;
        rd_en = 1'b1;
        step();
        arm   = 1'b0;
        rd_en = 1'b0;
        chk("rearm_rd_valid", int'(rd_valid), 0);
        chk("rearm_status", status(), 4);
        fill(0, 20, 20, 200);
        readout(0, 20, 0, DEPTH);

        // Reset five writes after the trigger.
        do_arm();
        fill(0, 20, 20, 26);
        apply_reset();
        rd_en = 1'b1;
        repeat (3) begin
            step();
            chk("post_abort_rd_valid", int'(rd_valid), 0);
            chk("post_abort_status", status(), 0);
        end
        rd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
